// File: rtl/glcpu_alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: states, instruction layout.
// Optional flag logic is enabled by defining GLCPU_FLAGS_EN.
package glcpu_alu_sequencer_pkg;

  localparam int NREG    = 4;
  localparam int FUNC_HI = 7;
  localparam int FUNC_LO = 5;
  localparam int DST_HI  = 4;
  localparam int DST_LO  = 3;
  localparam int SRC_HI  = 2;
  localparam int SRC_LO  = 1;
  localparam int IMM_BIT = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPERAND = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;
  localparam logic [1:0] ST_WB      = 2'd3;

  typedef struct packed {
    logic [2:0] func;
    logic [1:0] dst;
    logic [1:0] src;
    logic       imm;
  } instr_t;

  function automatic instr_t decode(input logic [7:0] b);
    instr_t r;
    r.func = b[FUNC_HI:FUNC_LO];
    r.dst  = b[DST_HI:DST_LO];
    r.src  = b[SRC_HI:SRC_LO];
    r.imm  = b[IMM_BIT];
    return r;
  endfunction

endpackage

// File: rtl/glcpu_alu_sequencer_regfile.sv
// 4-entry register file: two async operand reads, async debug read,
// one synchronous write, synchronous active-low reset to REG_INIT.
module glcpu_alu_sequencer_regfile
  import glcpu_alu_sequencer_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] REG_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREG];

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

  // Write port; reset reloads every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= REG_INIT;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/glcpu_alu_sequencer.sv
// ALU sequencer: accepts instructions/immediates, drives ALU select
// and operands, writes the result back. GLCPU_FLAGS_EN adds Z/C flags.
module glcpu_alu_sequencer
  import glcpu_alu_sequencer_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] REG_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             done,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [1:0]       state;
  instr_t           ir;
  instr_t           cur;
  logic [2:0]       sel;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             accept;

  // In IDLE the operands are read for the instruction being accepted,
  // so the register file is addressed straight from the input bus.
  assign cur = (state == ST_IDLE) ? decode(in_data[7:0]) : ir;

  assign in_ready = rst_n &&
                    (state == ST_IDLE || state == ST_OPERAND);
  assign accept   = in_valid && in_ready;
  assign done     = (state == ST_WB);
  assign busy     = (state != ST_IDLE);
  assign {s2, s1, s0} = sel;

  glcpu_alu_sequencer_regfile #(
    .WIDTH    (WIDTH),
    .REG_INIT (REG_INIT)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == ST_WB),
    .waddr    (ir.dst),
    .wdata    (result_q),
    .raddr_a  (cur.dst),
    .rdata_a  (rdata_a),
    .raddr_b  (cur.src),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // FSM, instruction latch, registered EXEC outputs, result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir       <= '0;
      sel      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      result_q <= '0;
    end else begin
      sel <= '0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            ir <= cur;
            if (cur.imm) begin
              state <= ST_OPERAND;
            end else begin
              state <= ST_EXEC;
              sel   <= cur.func;
              alu_a <= rdata_a;
              alu_b <= rdata_b;
            end
          end
        end
        ST_OPERAND: begin
          if (accept) begin
            state <= ST_EXEC;
            sel   <= ir.func;
            alu_a <= rdata_a;
            alu_b <= in_data;
          end
        end
        ST_EXEC: begin
          state    <= ST_WB;
          result_q <= alu_result;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GLCPU_FLAGS_EN
  logic carry_q;

  // Flags follow the value written back, updated on the WB edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      if (state == ST_EXEC)
        carry_q <= alu_carry;
      if (state == ST_WB) begin
        flag_z <= (result_q == '0);
        flag_c <= carry_q;
      end
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
